inst_fetch_bridge: RTL and testbench

- Memory-side responder for the fetch stage.
- Accepts the fetch address `pc` with its request strobe `pcn` and drives an SRAM-like split-handshake instruction bus.
- Returns the fetched word on `if_inst` and holds the fetch stage with `delay_hard` while the bus is busy.
- Reports misaligned fetches (`IADEE`) and bus timeouts (`IADFE`), and drops in-flight responses after a pipeline flush.

---
 rtl/inst_fetch_bridge.sv | 190 +++++++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge
//   Memory-side responder for the fetch stage. It takes a fetch address
//   (pc/pcn) and drives an SRAM-like split-handshake instruction bus. The
//   fetched word comes back on if_inst with a one-cycle inst_valid pulse.
//   delay_hard stalls the fetch stage while a bus transaction is open.
//   Misaligned fetches raise IADEE and bus timeouts raise IADFE. A flush
//   cancels the fetch in flight; its response is still drained, then dropped.
//
//   Optional feature, enabled with macro FETCH_LINE_BUF_EN: a single-entry
//   {addr, data} buffer answers a repeated fetch without a bus request.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   pc, pcn           fetch address and request strobe (sampled in IDLE)
//   flush             cancel the current fetch
//   if_inst           fetched word, meaningful when inst_valid=1
//   inst_valid        one-cycle pulse
//   delay_hard        stall, high while state != IDLE
//   IADEE, IADFE      misaligned-address / timeout fault pulses
//   inst_req, inst_addr, inst_addr_ok, inst_rdata, inst_data_ok   bus side
module inst_fetch_bridge #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pcn,
    input  logic        flush,
    output logic [31:0] if_inst,
    output logic        inst_valid,
    output logic        delay_hard,
    output logic        IADEE,
    output logic        IADFE,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t             state_q, state_d;
    logic [31:0]        if_inst_q, if_inst_d;
    logic               inst_valid_q, inst_valid_d;
    logic               iadee_q, iadee_d;
    logic               iadfe_q, iadfe_d;
    logic               inst_req_q, inst_req_d;
    logic [31:0]        inst_addr_q, inst_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               discard_q, discard_d;
    logic               busy;
    logic               data_now;

`ifdef FETCH_LINE_BUF_EN
    logic               buf_valid_q, buf_valid_d;
    logic [31:0]        buf_addr_q, buf_addr_d;
    logic [31:0]        buf_data_q, buf_data_d;
`endif

    assign busy     = (state_q != IDLE);
    // Response arriving this cycle; it beats a timeout landing on the same cycle.
    assign data_now = (state_q == DATA) && inst_data_ok;

    always_comb begin
        state_d      = state_q;
        if_inst_d    = if_inst_q;
        inst_valid_d = 1'b0;
        iadee_d      = 1'b0;
        iadfe_d      = 1'b0;
        inst_req_d   = inst_req_q;
        inst_addr_d  = inst_addr_q;
        cnt_d        = cnt_q;
        discard_d    = discard_q;
`ifdef FETCH_LINE_BUF_EN
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        if (flush) buf_valid_d = 1'b0;
`endif

        if (busy) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (flush) discard_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pcn && !flush) begin
                    if (pc[1:0] != 2'b00) begin
                        if_inst_d    = 32'h0;
                        inst_valid_d = 1'b1;
                        iadee_d      = 1'b1;
                    end
`ifdef FETCH_LINE_BUF_EN
                    else if (buf_valid_q && (buf_addr_q == pc)) begin
                        if_inst_d    = buf_data_q;
                        inst_valid_d = 1'b1;
                    end
`endif
                    else begin
                        inst_addr_d = pc;
                        inst_req_d  = 1'b1;
                        cnt_d       = '0;
                        discard_d   = 1'b0;
                        state_d     = ADDR;
                    end
                end
            end
            ADDR: begin
                // Request stays up until accepted, flushed or not.
                if (inst_addr_ok) begin
                    inst_req_d = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (inst_data_ok) begin
                    state_d = IDLE;
                    if (!discard_q && !flush) begin
                        if_inst_d    = inst_rdata;
                        inst_valid_d = 1'b1;
`ifdef FETCH_LINE_BUF_EN
                        buf_valid_d  = 1'b1;
                        buf_addr_d   = inst_addr_q;
                        buf_data_d   = inst_rdata;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Fault fires as the counter reaches MAX_WAIT; the transaction is then
        // marked discard so the late response is drained silently.
        if (busy && (cnt_q == CNT_LAST) && !discard_q && !flush && !data_now) begin
            if_inst_d    = 32'h0;
            inst_valid_d = 1'b1;
            iadfe_d      = 1'b1;
            discard_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            if_inst_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            iadee_q      <= 1'b0;
            iadfe_q      <= 1'b0;
            inst_req_q   <= 1'b0;
            inst_addr_q  <= 32'h0;
            cnt_q        <= '0;
            discard_q    <= 1'b0;
`ifdef FETCH_LINE_BUF_EN
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= 32'h0;
            buf_data_q   <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            if_inst_q    <= if_inst_d;
            inst_valid_q <= inst_valid_d;
            iadee_q      <= iadee_d;
            iadfe_q      <= iadfe_d;
            inst_req_q   <= inst_req_d;
            inst_addr_q  <= inst_addr_d;
            cnt_q        <= cnt_d;
            discard_q    <= discard_d;
`ifdef FETCH_LINE_BUF_EN
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
`endif
        end
    end

    assign if_inst    = if_inst_q;
    assign inst_valid = inst_valid_q;
    assign IADEE      = iadee_q;
    assign IADFE      = iadfe_q;
    assign inst_req   = inst_req_q;
    assign inst_addr  = inst_addr_q;
    assign delay_hard = busy;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Testbench for inst_fetch_bridge (MAX_WAIT=8). Each fetch is described as a
// transaction: A = cycles inst_addr_ok is withheld, D = cycles inst_data_ok is
// withheld after DATA entry, F = busy cycle carrying a flush (0 = none).
// Expected outcomes come from the timing arithmetic of the fetch protocol.
module tb_inst_fetch_bridge;

    localparam int MW = 8;
`ifdef FETCH_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pcn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] if_inst;
    logic        inst_valid, delay_hard, IADEE, IADFE, inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        inst_data_ok = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;

    // reference buffer contents (used only when the buffer feature is built)
    bit          m_bv = 1'b0;
    logic [31:0] m_ba = 32'h0;
    logic [31:0] m_bd = 32'h0;

    inst_fetch_bridge #(.MAX_WAIT(MW), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pcn(pcn), .flush(flush),
        .if_inst(if_inst), .inst_valid(inst_valid), .delay_hard(delay_hard),
        .IADEE(IADEE), .IADFE(IADFE), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata),
        .inst_data_ok(inst_data_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch request issued from IDLE; returns with the DUT back in IDLE.
    task automatic fetch(input logic [31:0] a_pc, input int A, input int D,
                         input int F, input logic [31:0] data);
        int  n;
        bit  flushed, delivered, fault;
        pc = a_pc; pcn = 1'b1; flush = 1'b0;
        chk("start_idle", 32'(delay_hard), 32'd0);
        step();
        pcn = 1'b0;
        pc  = $urandom;
        if (a_pc[1:0] != 2'b00) begin
            chk("mis_iadee", 32'(IADEE), 32'd1);
            chk("mis_valid", 32'(inst_valid), 32'd1);
            chk("mis_inst", if_inst, 32'h0);
            chk("mis_req", 32'(inst_req), 32'd0);
            chk("mis_dh", 32'(delay_hard), 32'd0);
            return;
        end
        if (BUF_EN && m_bv && m_ba == a_pc) begin
            chk("hit_valid", 32'(inst_valid), 32'd1);
            chk("hit_inst", if_inst, m_bd);
            chk("hit_req", 32'(inst_req), 32'd0);
            chk("hit_dh", 32'(delay_hard), 32'd0);
            return;
        end
        n         = A + D + 2;                  // busy cycles 1..n
        flushed   = (F >= 1) && (F <= n);
        delivered = (n <= MW) && !flushed;
        fault     = (n > MW) && !(flushed && F <= MW);
        for (int k = 1; k <= n; k++) begin
            inst_addr_ok = (k == A + 1);
            inst_data_ok = (k == n);
            inst_rdata   = (k == n) ? data : $urandom;
            flush        = (k == F);
            chk("busy_dh", 32'(delay_hard), 32'd1);
            chk("busy_req", 32'(inst_req), 32'(k <= A + 1));
            if (k <= A + 1) chk("busy_addr", inst_addr, a_pc);
            if (fault && k == MW + 1) begin
                chk("to_iadfe", 32'(IADFE), 32'd1);
                chk("to_valid", 32'(inst_valid), 32'd1);
                chk("to_inst", if_inst, 32'h0);
            end else begin
                chk("busy_valid", 32'(inst_valid), 32'd0);
                chk("busy_iadfe", 32'(IADFE), 32'd0);
            end
            step();
        end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; flush = 1'b0;
        chk("end_dh", 32'(delay_hard), 32'd0);
        chk("end_req", 32'(inst_req), 32'd0);
        chk("end_valid", 32'(inst_valid), 32'(delivered));
        chk("end_iadfe", 32'(IADFE), 32'd0);
        if (delivered) chk("end_inst", if_inst, data);
        if (flushed) m_bv = 1'b0;
        if (delivered) begin
            m_bv = 1'b1; m_ba = a_pc; m_bd = data;
        end
    endtask

    // Request and flush together in IDLE: flush wins, nothing happens.
    task automatic idle_flush(input logic [31:0] a_pc);
        pc = a_pc; pcn = 1'b1; flush = 1'b1;
        step();
        pcn = 1'b0; flush = 1'b0;
        chk("iflush_req", 32'(inst_req), 32'd0);
        chk("iflush_dh", 32'(delay_hard), 32'd0);
        chk("iflush_valid", 32'(inst_valid), 32'd0);
        m_bv = 1'b0;
    endtask

    initial begin
        int r, a, d, f;
        logic [31:0] p;
        reset = 1'b1;
        step(); step();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_addr", inst_addr, 32'h0);
        chk("rst_dh", 32'(delay_hard), 32'd0);
        chk("rst_iadee", 32'(IADEE), 32'd0);
        chk("rst_iadfe", 32'(IADFE), 32'd0);
        reset = 1'b0;
        step();

        fetch(32'hbfc0_0000, 0, 0, 0, 32'h2408_0001);   // zero wait
        fetch(32'hbfc0_0002, 0, 0, 0, 32'h0);           // misaligned
        fetch(32'hbfc0_0100, 0, 3, 2, 32'h1111_2222);   // flush in DATA
        fetch(32'hbfc0_0200, 5, 0, 0, 32'h3333_4444);   // addr backpressure
        fetch(32'hbfc0_0300, 12, 2, 0, 32'h5555_6666);  // timeout, late drop
        fetch(32'hbfc0_0304, 3, 3, 0, 32'h7777_8888);   // exactly MAX_WAIT: data wins

        fetch(32'hbfc0_0380, 0, 1, 0, 32'hcafe_0001);   // line buffer
        fetch(32'hbfc0_0380, 1, 0, 0, 32'hcafe_0002);
        idle_flush(32'hbfc0_0380);
        fetch(32'hbfc0_0380, 0, 0, 0, 32'hcafe_0003);

        // reset in the middle of a transaction
        pc = 32'hbfc0_0400; pcn = 1'b1;
        step();
        pcn = 1'b0;
        chk("mid_req", 32'(inst_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_bv = 1'b0;
        chk("mid_rst_req", 32'(inst_req), 32'd0);
        chk("mid_rst_dh", 32'(delay_hard), 32'd0);
        chk("mid_rst_addr", inst_addr, 32'h0);
        step();

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                idle_flush(32'hbfc0_0000 + 32'($urandom_range(0, 3) << 4));
            end else if (r == 1) begin
                fetch(32'hbfc0_0000 | 32'($urandom_range(1, 3)), 0, 0, 0, 32'h0);
            end else begin
                p = 32'hbfc0_0000 + 32'($urandom_range(0, 3) << 4);
                a = $urandom_range(0, 7);
                d = $urandom_range(0, 7);
                f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, a + d + 2) : 0;
                fetch(p, a, d, f, $urandom);
            end
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
